// File: rtl/puf_response_voter.sv
// Majority voter for an arbiter PUF: drives a challenge, waits to settle, then votes N_VOTES samples.
// Define PUF_VOTE_MASK_EN to add the per-bit Unstable (non-unanimous) output.
module puf_response_voter #(
    parameter int unsigned C_LENGTH      = 32,
    parameter int unsigned N_VOTES       = 7,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                In_valid,
    output logic                In_ready,
    input  logic [C_LENGTH-1:0] In_challenge,
    output logic [C_LENGTH-1:0] Puf_challenge,
    input  logic [C_LENGTH-1:0] Puf_response,
    output logic                Out_valid,
    input  logic                Out_ready,
    output logic [C_LENGTH-1:0] Out_response,
`ifdef PUF_VOTE_MASK_EN
    output logic [C_LENGTH-1:0] Unstable,
`endif
    output logic [C_LENGTH-1:0] Out_challenge
);

    localparam int unsigned CW = $clog2(N_VOTES + 1);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] HALF        = CW'(N_VOTES / 2);
    localparam logic [CW-1:0] LAST        = CW'(N_VOTES - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
`ifdef PUF_VOTE_MASK_EN
    localparam logic [CW-1:0] FULL        = CW'(N_VOTES);
`endif

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    state_e              state_q;
    logic [SW-1:0]       settle_q;
    logic [CW-1:0]       sample_q;
    logic [CW-1:0]       cnt_q [C_LENGTH];
    logic [CW-1:0]       total [C_LENGTH];
    logic [C_LENGTH-1:0] vote;
`ifdef PUF_VOTE_MASK_EN
    logic [C_LENGTH-1:0] mixed;
`endif

    // Totals include the sample arriving this cycle so the last sample can be voted directly.
    always_comb begin
        for (int i = 0; i < int'(C_LENGTH); i++) begin
            total[i] = cnt_q[i] + CW'(Puf_response[i]);
            vote[i]  = total[i] > HALF;
`ifdef PUF_VOTE_MASK_EN
            mixed[i] = (total[i] != '0) && (total[i] != FULL);
`endif
        end
    end

    assign In_ready  = (state_q == StIdle);
    assign Out_valid = (state_q == StDone);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q       <= StIdle;
            settle_q      <= '0;
            sample_q      <= '0;
            Puf_challenge <= '0;
            Out_challenge <= '0;
            Out_response  <= '0;
`ifdef PUF_VOTE_MASK_EN
            Unstable      <= '0;
`endif
            for (int i = 0; i < int'(C_LENGTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (In_valid) begin
                        Puf_challenge <= In_challenge;
                        Out_challenge <= In_challenge;
                        settle_q      <= SETTLE_LOAD;
                        sample_q      <= '0;
                        for (int i = 0; i < int'(C_LENGTH); i++) begin
                            cnt_q[i] <= '0;
                        end
                        state_q <= StSettle;
                    end
                end
                StSettle: begin
                    if (settle_q == '0) begin
                        state_q <= StSample;
                    end else begin
                        settle_q <= settle_q - SW'(1);
                    end
                end
                StSample: begin
                    for (int i = 0; i < int'(C_LENGTH); i++) begin
                        cnt_q[i] <= total[i];
                    end
                    sample_q <= sample_q + CW'(1);
                    if (sample_q == LAST) begin
                        Out_response <= vote;
`ifdef PUF_VOTE_MASK_EN
                        Unstable     <= mixed;
`endif
                        state_q      <= StDone;
                    end
                end
                StDone: begin
                    if (Out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
